main_memory_write_controller: RTL and testbench
===============================================

MAIN_MEMORY_WRITE_CONTROLLER -- requirements
Module: main_memory_write_controller

Interface
REQ-001 SHALL have parameter ADC_MAX_DATA_SIZE, default 16, giving bits per packed slot (range 8-16; host word zero-extended/truncated to it).
REQ-002 SHALL have parameter BRAM_WORD_NUM, default 8, giving slots per packed word (range 8-64, power of 2).
REQ-003 SHALL have one clock and one reset: i_write_mux_wr_clk and i_write_mux_reset_n; reset is synchronous and active-low.
REQ-004 i_write_mux_wr_clk  in  1  single clock for all logic.
REQ-005 i_write_mux_reset_n  in  1  synchronous active-low reset.
REQ-006 i_write_mux_wr_async_n  in  1  Blackfin AMS chip select, active low, asynchronous.
REQ-007 i_write_mux_wr_awe_n  in  1  Blackfin write strobe, active low, asynchronous.
REQ-008 i_write_mux_data  in  16  host write data, stable while awe_n low.
REQ-009 i_write_mux_flush  in  1  pulse; emit a partial word.
REQ-010 i_write_mux_ovf_clr  in  1  pulse; clear overflow flag.
REQ-011 i_write_mux_ready  in  1  downstream memory accepts word.
REQ-012 o_write_mux_data  out  ADC_MAX_DATA_SIZE*BRAM_WORD_NUM  packed word.
REQ-013 o_write_mux_valid  out  1  packed word available.
REQ-014 o_write_mux_cnt  out  $clog2(BRAM_WORD_NUM)  slots filled in current word.
REQ-015 o_write_mux_busy  out  1  host must hold off next write.
REQ-016 o_write_mux_overflow  out  1  sticky; a completed word was dropped.

Function
REQ-017 SHALL synchronise awe_n and async_n through 2 flops and detect a write event as synced awe_n falling while synced async_n low.
REQ-018 SHALL sample i_write_mux_data through the same 2-stage delay so data aligns with the write event.
REQ-019 On a write event SHALL store the word into slot cnt (slot 0 in LSBs) and increment cnt, 1-cycle latency.
REQ-020 When the write fills slot BRAM_WORD_NUM-1 SHALL transfer the packed word to the output register, assert valid next cycle, and wrap cnt to 0.
REQ-021 valid SHALL stay high and data stable until a cycle with valid and ready both high; valid drops the following cycle unless a new word loads in that same cycle.
REQ-022 If a word completes while valid high and ready low, SHALL drop the new word, set overflow, keep the held word, and wrap cnt to 0.
REQ-023 busy SHALL equal valid AND (cnt == BRAM_WORD_NUM-1).
REQ-024 Flush with cnt>0 SHALL zero-fill unused slots and load as in REQ-020/022; flush with cnt==0 SHALL be a no-op.
REQ-025 Write event and flush in the same cycle SHALL store the write first; the flushed word includes it.
REQ-026 ovf_clr SHALL clear overflow unless an overflow occurs the same cycle (set wins).
REQ-027 Write events with async_n high, and awe_n held low, SHALL produce no further events.

Reset
REQ-028 Reset low SHALL force data=0, valid=0, cnt=0, busy=0, overflow=0, synchronisers to idle-high, discarding any partial word, including mid-operation.

Configuration
REQ-029 Macro MAIN_MEMORY_WR_TEST_PATTERN_EN, when defined, SHALL add input i_write_mux_pattern_en; when high, each write event stores an incrementing 16-bit counter (reset 0, wraps 0xFFFF->0) instead of host data.
REQ-030 Without MAIN_MEMORY_WR_TEST_PATTERN_EN, the port and counter SHALL not exist and host data is always stored.

Structure
REQ-031 Shared package main_memory_pkg SHALL hold host word width (16) and synchroniser depth (2).
REQ-032 Sub-module main_memory_sync_edge SHALL implement 2-flop synchroniser plus falling-edge detect, instantiated for awe_n; async_n uses sync only.

Verification
REQ-033 8 host writes 0x0001..0x0008, ready=1 -> one valid pulse, data slot0=0x0001..slot7=0x0008, cnt back to 0.
REQ-034 ready=0, 16 writes -> first word held; second completes -> overflow=1, busy high after 15th write, held data unchanged; ovf_clr -> overflow=0.
REQ-035 3 writes 0xAAAA,0xBBBB,0xCCCC then flush -> valid, slots 3-7 zero; flush at cnt=0 -> no valid.
REQ-036 Reset asserted after 5 writes -> cnt=0, valid=0; next 8 writes produce a word with no prior data.
REQ-037 Strobe pulses with async_n high, and awe_n held low 10 cycles -> 0 and 1 event respectively.
REQ-038 With MAIN_MEMORY_WR_TEST_PATTERN_EN and pattern_en=1, 8 writes -> slots 0x0000..0x0007 regardless of host data.

Source files
------------

// File: rtl/main_memory_pkg.sv
// Shared constants for the main-memory write path: host bus width and
// synchroniser depth used by the write controller and its edge detector.
package main_memory_pkg;
  localparam int HOST_WORD_W = 16;
  localparam int SYNC_DEPTH  = 2;
endpackage

// File: rtl/main_memory_sync_edge.sv
// Multi-flop synchroniser for an asynchronous active-low strobe, followed by
// a falling-edge detector on the synchronised level.
module main_memory_sync_edge
  import main_memory_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;

  // Idle level of the strobe is high, so the chain resets high and no
  // spurious edge is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
      prev_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign fall = prev_q & ~sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/main_memory_write_controller.sv
// Packs asynchronous Blackfin host writes into wide words for main memory.
// Optional MAIN_MEMORY_WR_TEST_PATTERN_EN replaces host data with a counter.
module main_memory_write_controller
  import main_memory_pkg::*;
#(
  parameter int ADC_MAX_DATA_SIZE = 16,
  parameter int BRAM_WORD_NUM     = 8
) (
  input  logic                                       i_write_mux_wr_clk,
  input  logic                                       i_write_mux_reset_n,
  input  logic                                       i_write_mux_wr_async_n,
  input  logic                                       i_write_mux_wr_awe_n,
  input  logic [HOST_WORD_W-1:0]                     i_write_mux_data,
  input  logic                                       i_write_mux_flush,
  input  logic                                       i_write_mux_ovf_clr,
  input  logic                                       i_write_mux_ready,
`ifdef MAIN_MEMORY_WR_TEST_PATTERN_EN
  input  logic                                       i_write_mux_pattern_en,
`endif
  output logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] o_write_mux_data,
  output logic                                       o_write_mux_valid,
  output logic [$clog2(BRAM_WORD_NUM)-1:0]           o_write_mux_cnt,
  output logic                                       o_write_mux_busy,
  output logic                                       o_write_mux_overflow
);

  localparam int                CNT_W     = $clog2(BRAM_WORD_NUM);
  localparam int                WORD_W    = ADC_MAX_DATA_SIZE * BRAM_WORD_NUM;
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(BRAM_WORD_NUM - 1);

  logic [SYNC_DEPTH-1:0][HOST_WORD_W-1:0] data_pipe_q;
  logic [SYNC_DEPTH-1:0]                  async_pipe_q;
  logic                                   awe_fall;
  logic                                   write_ev;
  logic [HOST_WORD_W-1:0]                 selected_word;
  logic [ADC_MAX_DATA_SIZE-1:0]           slot_word;
  logic [WORD_W-1:0]                      accum_q;
  logic [WORD_W-1:0]                      merged;
  logic [CNT_W-1:0]                       cnt_q;
  logic [WORD_W-1:0]                      out_data_q;
  logic                                   valid_q;
  logic                                   overflow_q;
  logic                                   fill;
  logic                                   flush_go;
  logic                                   complete;
  logic                                   handshake;
  logic                                   load;
  logic                                   ovf_set;

  main_memory_sync_edge u_awe_sync (
    .clk      (i_write_mux_wr_clk),
    .reset_n  (i_write_mux_reset_n),
    .async_in (i_write_mux_wr_awe_n),
    .fall     (awe_fall)
  );

  assign write_ev = awe_fall & ~async_pipe_q[SYNC_DEPTH-1];

`ifdef MAIN_MEMORY_WR_TEST_PATTERN_EN
  logic [HOST_WORD_W-1:0] pattern_q;

  always_ff @(posedge i_write_mux_wr_clk) begin
    if (!i_write_mux_reset_n) begin
      pattern_q <= '0;
    end else if (write_ev && i_write_mux_pattern_en) begin
      pattern_q <= pattern_q + HOST_WORD_W'(1);
    end
  end

  assign selected_word = i_write_mux_pattern_en ? pattern_q : data_pipe_q[SYNC_DEPTH-1];
`else
  assign selected_word = data_pipe_q[SYNC_DEPTH-1];
`endif

  assign slot_word = ADC_MAX_DATA_SIZE'(selected_word);

  // The accumulator is cleared on every completed word, so slots above cnt
  // are already zero and a flushed partial word needs no extra masking.
  always_comb begin
    merged = accum_q;
    if (write_ev) begin
      merged[cnt_q*ADC_MAX_DATA_SIZE +: ADC_MAX_DATA_SIZE] = slot_word;
    end
  end

  assign fill      = write_ev && (cnt_q == LAST_SLOT);
  assign flush_go  = i_write_mux_flush && ((cnt_q != '0) || write_ev);
  assign complete  = fill || flush_go;
  assign handshake = valid_q && i_write_mux_ready;
  assign load      = complete && (!valid_q || handshake);
  assign ovf_set   = complete && valid_q && !i_write_mux_ready;

  always_ff @(posedge i_write_mux_wr_clk) begin
    if (!i_write_mux_reset_n) begin
      data_pipe_q  <= '0;
      async_pipe_q <= '1;
      accum_q      <= '0;
      cnt_q        <= '0;
      out_data_q   <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      data_pipe_q  <= {data_pipe_q[SYNC_DEPTH-2:0], i_write_mux_data};
      async_pipe_q <= {async_pipe_q[SYNC_DEPTH-2:0], i_write_mux_wr_async_n};

      if (complete) begin
        accum_q <= '0;
        cnt_q   <= '0;
      end else begin
        accum_q <= merged;
        if (write_ev) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      if (load) begin
        out_data_q <= merged;
        valid_q    <= 1'b1;
      end else if (handshake) begin
        valid_q    <= 1'b0;
      end

      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (i_write_mux_ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign o_write_mux_data     = out_data_q;
  assign o_write_mux_valid    = valid_q;
  assign o_write_mux_cnt      = cnt_q;
  assign o_write_mux_busy     = valid_q && (cnt_q == LAST_SLOT);
  assign o_write_mux_overflow = overflow_q;

endmodule

// File: tb/tb_main_memory_write_controller.sv
// Directed bench for main_memory_write_controller: table-driven packing plus
// hand sequences for backpressure, flush, reset, and strobe qualification.
module tb_main_memory_write_controller;

  logic         clk;
  logic         reset_n;
  logic         async_n;
  logic         awe_n;
  logic [15:0]  data;
  logic         flush;
  logic         ovf_clr;
  logic         ready;
`ifdef MAIN_MEMORY_WR_TEST_PATTERN_EN
  logic         pattern_en;
`endif
  logic [127:0] o_data;
  logic         o_valid;
  logic [2:0]   o_cnt;
  logic         o_busy;
  logic         o_overflow;

  int           checks;
  int           failures;
  int           hs_count;
  logic [127:0] hs_data;
  int           hs_base;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  exp_cnt;
    int          exp_hs;
  } vec_t;

  vec_t vecs[8];

  main_memory_write_controller dut (
    .i_write_mux_wr_clk     (clk),
    .i_write_mux_reset_n    (reset_n),
    .i_write_mux_wr_async_n (async_n),
    .i_write_mux_wr_awe_n   (awe_n),
    .i_write_mux_data       (data),
    .i_write_mux_flush      (flush),
    .i_write_mux_ovf_clr    (ovf_clr),
    .i_write_mux_ready      (ready),
`ifdef MAIN_MEMORY_WR_TEST_PATTERN_EN
    .i_write_mux_pattern_en (pattern_en),
`endif
    .o_write_mux_data       (o_data),
    .o_write_mux_valid      (o_valid),
    .o_write_mux_cnt        (o_cnt),
    .o_write_mux_busy       (o_busy),
    .o_write_mux_overflow   (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted word as the coming posedge will see it.
  initial begin
    hs_count = 0;
    hs_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (o_valid && ready) begin
        hs_count = hs_count + 1;
        hs_data  = o_data;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // One host write: strobe low for four cycles, optional ovf_clr/flush pulse
  // landing on the same edge that stores the word.
  task automatic apply_stimulus(input logic [15:0] d, input bit clr_at_store, input bit flush_at_store);
    @(negedge clk);
    data    = d;
    async_n = 1'b0;
    awe_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ovf_clr = clr_at_store;
    flush   = flush_at_store;
    @(negedge clk);
    ovf_clr = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    awe_n   = 1'b1;
    async_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    async_n  = 1'b1;
    awe_n    = 1'b1;
    data     = '0;
    flush    = 1'b0;
    ovf_clr  = 1'b0;
    ready    = 1'b1;
`ifdef MAIN_MEMORY_WR_TEST_PATTERN_EN
    pattern_en = 1'b0;
`endif

    for (int i = 0; i < 8; i++) begin
      vecs[i].data    = 16'(i + 1);
      vecs[i].exp_cnt = 3'((i + 1) % 8);
      vecs[i].exp_hs  = (i == 7) ? 1 : 0;
    end

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("reset_data", o_data, '0);
    check_output("reset_valid", 128'(o_valid), 128'd0);
    check_output("reset_cnt", 128'(o_cnt), 128'd0);
    check_output("reset_busy", 128'(o_busy), 128'd0);
    check_output("reset_ovf", 128'(o_overflow), 128'd0);

    // Full word with ready high
    hs_base = hs_count;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].data, 1'b0, 1'b0);
      check_output($sformatf("vec%0d_cnt", i), 128'(o_cnt), 128'(vecs[i].exp_cnt));
      check_output($sformatf("vec%0d_hs", i), 128'(hs_count - hs_base), 128'(vecs[i].exp_hs));
    end
    check_output("full_word_data", hs_data,
      {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001});
    check_output("full_word_valid_drop", 128'(o_valid), 128'd0);

    // Backpressure and overflow
    ready   = 1'b0;
    hs_base = hs_count;
    for (int i = 1; i <= 8; i++) apply_stimulus(16'(16'h1000 + i), 1'b0, 1'b0);
    check_output("bp_valid_held", 128'(o_valid), 128'd1);
    for (int i = 1; i <= 6; i++) apply_stimulus(16'(16'h2000 + i), 1'b0, 1'b0);
    check_output("bp_busy_14", 128'(o_busy), 128'd0);
    apply_stimulus(16'h2007, 1'b0, 1'b0);
    check_output("bp_busy_15", 128'(o_busy), 128'd1);
    check_output("bp_ovf_before", 128'(o_overflow), 128'd0);
    apply_stimulus(16'h2008, 1'b1, 1'b0);
    check_output("bp_ovf_set_wins", 128'(o_overflow), 128'd1);
    check_output("bp_cnt_wrap", 128'(o_cnt), 128'd0);
    check_output("bp_held_data", o_data,
      {16'h1008, 16'h1007, 16'h1006, 16'h1005, 16'h1004, 16'h1003, 16'h1002, 16'h1001});
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_output("bp_ovf_clr", 128'(o_overflow), 128'd0);
    check_output("bp_no_hs", 128'(hs_count - hs_base), 128'd0);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("bp_release_hs", 128'(hs_count - hs_base), 128'd1);
    check_output("bp_release_valid", 128'(o_valid), 128'd0);

    // Partial word flush, then a flush with nothing pending
    hs_base = hs_count;
    apply_stimulus(16'hAAAA, 1'b0, 1'b0);
    apply_stimulus(16'hBBBB, 1'b0, 1'b0);
    apply_stimulus(16'hCCCC, 1'b0, 1'b0);
    check_output("flush_cnt_pre", 128'(o_cnt), 128'd3);
    pulse_flush();
    check_output("flush_hs", 128'(hs_count - hs_base), 128'd1);
    check_output("flush_data", hs_data, {80'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA});
    check_output("flush_cnt_post", 128'(o_cnt), 128'd0);
    pulse_flush();
    check_output("flush_empty_hs", 128'(hs_count - hs_base), 128'd1);
    check_output("flush_empty_valid", 128'(o_valid), 128'd0);

    // Write and flush on the same edge
    hs_base = hs_count;
    apply_stimulus(16'h1111, 1'b0, 1'b0);
    apply_stimulus(16'h2222, 1'b0, 1'b1);
    check_output("wrflush_hs", 128'(hs_count - hs_base), 128'd1);
    check_output("wrflush_data", hs_data, {96'h0, 16'h2222, 16'h1111});
    check_output("wrflush_cnt", 128'(o_cnt), 128'd0);

    // Reset in the middle of a partial word
    for (int i = 1; i <= 5; i++) apply_stimulus(16'(16'h3000 + i), 1'b0, 1'b0);
    check_output("rst_cnt_pre", 128'(o_cnt), 128'd5);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_output("rst_mid_cnt", 128'(o_cnt), 128'd0);
    check_output("rst_mid_valid", 128'(o_valid), 128'd0);
    hs_base = hs_count;
    for (int i = 1; i <= 8; i++) apply_stimulus(16'(16'h5000 + i), 1'b0, 1'b0);
    check_output("rst_word_hs", 128'(hs_count - hs_base), 128'd1);
    check_output("rst_word_data", hs_data,
      {16'h5008, 16'h5007, 16'h5006, 16'h5005, 16'h5004, 16'h5003, 16'h5002, 16'h5001});

    // Strobes without chip select, then one long strobe
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      data  = 16'hDEAD;
      awe_n = 1'b0;
      repeat (4) @(negedge clk);
      awe_n = 1'b1;
      repeat (4) @(negedge clk);
    end
    check_output("nocs_cnt", 128'(o_cnt), 128'd0);
    @(negedge clk);
    data    = 16'h7777;
    async_n = 1'b0;
    awe_n   = 1'b0;
    repeat (10) @(negedge clk);
    check_output("long_strobe_cnt_low", 128'(o_cnt), 128'd1);
    awe_n   = 1'b1;
    async_n = 1'b1;
    repeat (4) @(negedge clk);
    check_output("long_strobe_cnt", 128'(o_cnt), 128'd1);
    hs_base = hs_count;
    pulse_flush();
    check_output("long_strobe_data", hs_data, {112'h0, 16'h7777});

`ifdef MAIN_MEMORY_WR_TEST_PATTERN_EN
    // Test pattern replaces host data with a counter starting at zero
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    pattern_en = 1'b1;
    for (int i = 0; i < 8; i++) apply_stimulus(16'hBEEF, 1'b0, 1'b0);
    check_output("pattern_data", hs_data,
      {16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000});
    pattern_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
